// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and result flag layout.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 3'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 3'd3;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 3'd4;
  localparam logic [ALU_OPW-1:0] ALU_NAND = 3'd5;
  localparam logic [ALU_OPW-1:0] ALU_NOR  = 3'd6;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 3'd7;

  // Flag bits packed MSB first as {overflow, carry, zero}.
  typedef struct packed {
    logic overflow;
    logic carry;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_bitwise_unit.sv
// Combinational bitwise lanes: one XOR/AND/OR gate slice per bit, selected by opcode.
module alu_bitwise_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic [OPW-1:0]   op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  logic sel_xor, sel_and, sel_nand, sel_nor, sel_or;

  assign sel_xor  = (op_i == OPW'(ALU_XOR));
  assign sel_and  = (op_i == OPW'(ALU_AND));
  assign sel_nand = (op_i == OPW'(ALU_NAND));
  assign sel_nor  = (op_i == OPW'(ALU_NOR));
  assign sel_or   = (op_i == OPW'(ALU_OR));

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic x_bit, a_bit, o_bit;
    assign x_bit = a_i[i] ^ b_i[i];
    assign a_bit = a_i[i] & b_i[i];
    assign o_bit = a_i[i] | b_i[i];
    assign y_o[i] = (sel_xor  &  x_bit) |
                    (sel_and  &  a_bit) |
                    (sel_nand & ~a_bit) |
                    (sel_nor  & ~o_bit) |
                    (sel_or   &  o_bit);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one shared adder, SLT, bitwise lanes and a 2-entry result FIFO.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } entry_t;

  logic             sub_like;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] bw_y;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;
  entry_t           new_entry;

  alu_bitwise_unit #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_bitwise (
    .op_i (in_op),
    .a_i  (in_a),
    .b_i  (in_b),
    .y_o  (bw_y)
  );

  // SUB and SLT share the adder as a + ~b + 1.
  assign sub_like = (in_op == OPW'(ALU_SUB)) | (in_op == OPW'(ALU_SLT));
  assign b_eff    = sub_like ? ~in_b : in_b;
  assign sum      = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_like};
  assign add_ovf  = (in_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);

  always_comb begin
    res       = bw_y;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (in_op)
      OPW'(ALU_ADD), OPW'(ALU_SUB): begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = add_ovf;
      end
      OPW'(ALU_SLT): res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: ;
    endcase
  end

  assign new_entry.result         = res;
  assign new_entry.flags.overflow = res_ovf;
  assign new_entry.flags.carry    = res_carry;
  assign new_entry.flags.zero     = (res == '0);

  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       live_q;
  entry_t     mem_q [2];
  logic       push, pop;
  entry_t     head_e;

  // live_q keeps in_ready low during reset and for the edge of release.
  assign in_ready  = live_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    head_d  = pop  ? ~head_q : head_q;
    tail_d  = push ? ~tail_q : tail_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      live_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      live_q  <= 1'b1;
      if (push) mem_q[tail_q] <= new_entry;
    end
  end

  assign head_e       = mem_q[head_q];
  assign out_result   = head_e.result;
  assign out_zero     = head_e.flags.zero;
  assign out_carry    = head_e.flags.carry;
  assign out_overflow = head_e.flags.overflow;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vectors, backpressure, reset and random traffic.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_stage #(
    .WIDTH (32),
    .OPW   (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Observed head packed as {result, zero, carry, overflow}.
  wire [34:0] head_obs = {out_result, out_zero, out_carry, out_overflow};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic definitions of each opcode.
  function automatic logic [34:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb, r;
    logic [31:0] res;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r   = ua + ub;
        res = a + b;
        c   = (r > 64'sd4294967295);
        r   = sa + sb;
        v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd1: begin
        res = a - b;
        c   = (a >= b);
        r   = sa - sb;
        v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd2: res = a ^ b;
      3'd3: res = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: res = a & b;
      3'd5: res = ~(a & b);
      3'd6: res = ~(a | b);
      default: res = a | b;
    endcase
    return {res, (res == 32'd0), c, v};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (head_obs !== 35'd0) begin n_fail++; $display("FAIL reset_head: got %h expected 0", head_obs); end
    #2 reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre_edge: got %b expected 0", in_ready); end
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [12] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd1, 3'd3, 3'd3, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] as   [12] = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                               32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000005,
                               32'hF0F0A5A5, 32'hFFFFFFFF, 32'h00000000, 32'h12340000};
    logic [31:0] bs   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001,
                               32'h00000001, 32'h00000001, 32'h7FFFFFFF, 32'h00000005,
                               32'h0FF0FFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00005678};
    logic [34:0] exps [12] = '{{32'h00000000, 3'b100}, {32'hFFFFFFFF, 3'b000},
                               {32'h80000000, 3'b001}, {32'h00000000, 3'b110},
                               {32'hFFFFFFFF, 3'b000}, {32'h00000001, 3'b000},
                               {32'h00000001, 3'b000}, {32'h00000000, 3'b110},
                               {32'h00F0A5A5, 3'b000}, {32'h00000000, 3'b100},
                               {32'hFFFFFFFF, 3'b000}, {32'h12345678, 3'b000}};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_op = ops[i]; in_a = as[i]; in_b = bs[i];
      step();
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL directed_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++;
      if (head_obs !== exps[i])
        begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, head_obs, exps[i]); end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_drain[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, a2, b2;
    logic [34:0] e0, e1, e2;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e0 = ref_alu(3'd0, a0, b0);
    e1 = ref_alu(3'd2, a1, b1);
    e2 = ref_alu(3'd7, a2, b2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = a0; in_b = b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_1: got %b expected 1", in_ready); end
    n_checks++;
    if (head_obs !== e0) begin n_fail++; $display("FAIL b2b_head_add: got %h expected %h", head_obs, e0); end
    in_op = 3'd2; in_a = a1; in_b = b1;
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", in_ready); end
    in_op = 3'd7; in_a = a2; in_b = b2;
    step();
    n_checks++;
    if (head_obs !== e0 || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_head_stable: got %h expected %h", head_obs, e0); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (head_obs !== e1 || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_drain_xor: got %h expected %h", head_obs, e1); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (head_obs !== e2 || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_drain_or: got %h expected %h", head_obs, e2); end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [34:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'h11111111; in_b = 32'h22222222;
    step();
    in_op = 3'd1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL mid_full: got valid=%b ready=%b expected 1 0", out_valid, in_ready); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (head_obs !== 35'd0) begin n_fail++; $display("FAIL mid_async_head: got %h expected 0", head_obs); end
    step();
    #2 reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_pre_edge: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_after_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
    a = $urandom; b = $urandom;
    e = ref_alu(3'd3, a, b);
    in_valid = 1'b1; in_op = 3'd3; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || head_obs !== e)
      begin n_fail++; $display("FAIL mid_next_op: got %b/%h expected 1/%h", out_valid, head_obs, e); end
    step();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [34:0] q[$];
    logic        push, pop;
    logic [34:0] e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if (in_ready !== (q.size() < 2))
        begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, in_ready, q.size() < 2); end
      n_checks++;
      if (out_valid !== (q.size() > 0))
        begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", cyc, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_checks++;
        if (head_obs !== q[0])
          begin n_fail++; $display("FAIL rand_head[%0d]: got %h expected %h", cyc, head_obs, q[0]); end
      end
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      in_op = 3'($urandom);
      in_a  = pick_operand();
      in_b  = pick_operand();
      e    = ref_alu(in_op, in_a, in_b);
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      step();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
